// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller:
// FSM states, opcodes, datapath select codes and ALU operations.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RD1   = 2'b10;

    localparam logic [1:0] B_RD2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format depends on the opcode alone, not on the state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction fields to ALUControl.
// Ports: alu_op_i, op5_i, funct3_i, funct7b5_i -> alu_control_o.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // sub only for R-type; addi ignores instr[30]
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controlling a multicycle RV32I-subset datapath
// (lw, sw, R-type, I-ALU, beq, jal) over one shared ALU and memory.
// Ports: clk, reset (sync, active-high), op/funct3/funct7b5/zero in;
// PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
// ImmSrc, RegWrite, ALUControl, illegal out.
// Option MC_CTRL_MEM_WAIT_EN: adds mem_ready; memory states stall
// until it is high.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ILLEGAL_HALT = 1,
    parameter int STATE_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    logic [STATE_W-1:0] state_q, state_d;
    logic       ready;
    logic       pc_update, branch;
    logic       ir_w, mem_w, reg_w, ill;
    logic [1:0] alu_op;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    function automatic logic [STATE_W-1:0] st(input state_e s);
        return STATE_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= st(S_FETCH);
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = st(S_FETCH);
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        ill       = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = A_PC;
        ALUSrcB   = B_RD2;
        alu_op    = ALUOP_ADD;
        case (state_q)
            st(S_FETCH): begin
                ir_w      = ready;
                pc_update = ready;
                ALUSrcB   = B_FOUR;
                ResultSrc = RES_ALURES;
                state_d   = ready ? st(S_DECODE) : st(S_FETCH);
            end
            st(S_DECODE): begin
                // precompute branch target into ALUOut
                ALUSrcA = A_OLDPC;
                ALUSrcB = B_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = st(S_MEMADR);
                    OP_R:         state_d = st(S_EXECR);
                    OP_I:         state_d = st(S_EXECI);
                    OP_JAL:       state_d = st(S_JAL);
                    OP_BEQ:       state_d = st(S_BEQ);
                    default:      state_d = st(S_ILLEGAL);
                endcase
            end
            st(S_MEMADR): begin
                ALUSrcA = A_RD1;
                ALUSrcB = B_IMM;
                state_d = op[5] ? st(S_MEMWRITE) : st(S_MEMREAD);
            end
            st(S_MEMREAD): begin
                AdrSrc  = 1'b1;
                state_d = ready ? st(S_MEMWB) : st(S_MEMREAD);
            end
            st(S_MEMWB): begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            st(S_MEMWRITE): begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = ready ? st(S_FETCH) : st(S_MEMWRITE);
            end
            st(S_EXECR): begin
                ALUSrcA = A_RD1;
                alu_op  = ALUOP_FUNCT;
                state_d = st(S_ALUWB);
            end
            st(S_EXECI): begin
                ALUSrcA = A_RD1;
                ALUSrcB = B_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = st(S_ALUWB);
            end
            st(S_ALUWB): reg_w = 1'b1;
            st(S_JAL): begin
                // rd gets OldPC+4 next cycle; PC takes target from ALUOut
                ALUSrcA   = A_OLDPC;
                ALUSrcB   = B_FOUR;
                pc_update = 1'b1;
                state_d   = st(S_ALUWB);
            end
            st(S_BEQ): begin
                ALUSrcA = A_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            st(S_ILLEGAL): begin
                ill     = 1'b1;
                state_d = (ILLEGAL_HALT != 0) ? st(S_ILLEGAL) : st(S_FETCH);
            end
            default: state_d = st(S_FETCH);
        endcase
    end

    // Enables are killed during reset so an abandoned instruction
    // leaves no partial write behind.
    assign PCWrite  = ~reset & (pc_update | (branch & zero));
    assign IRWrite  = ~reset & ir_w;
    assign MemWrite = ~reset & mem_w;
    assign RegWrite = ~reset & reg_w;
    assign illegal  = ~reset & ill;
    assign ImmSrc   = imm_src(op);

    alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios
// plus randomized instruction streams against a cycle-level model.
module tb_multicycle_controller;

    localparam int C_LW  = 0;
    localparam int C_SW  = 1;
    localparam int C_R   = 2;
    localparam int C_I   = 3;
    localparam int C_JAL = 4;
    localparam int C_BEQ = 5;
    localparam int C_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;

    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] aluc;
    logic       pcw0, adr0, mw0, irw0, rw0, ill0;
    logic [1:0] res0, sa0, sb0, imm0;
    logic [2:0] aluc0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_HALT(1)) dut (
        .clk(clk), .reset(reset),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw),
        .ResultSrc(res), .ALUSrcA(sa), .ALUSrcB(sb), .ImmSrc(imm),
        .RegWrite(rw), .ALUControl(aluc), .illegal(ill)
    );

    multicycle_controller #(.ILLEGAL_HALT(0)) dut0 (
        .clk(clk), .reset(reset),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
        .ResultSrc(res0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0),
        .RegWrite(rw0), .ALUControl(aluc0), .illegal(ill0)
    );

    wire [16:0] act  = {pcw, adr, mw, irw, res, sa, sb, imm, rw, aluc, ill};
    wire [16:0] act0 = {pcw0, adr0, mw0, irw0, res0, sa0, sb0, imm0, rw0, aluc0, ill0};

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_JAL:   return 7'b1101111;
            C_BEQ:   return 7'b1100011;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int ncyc(input int cls);
        case (cls)
            C_LW:    return 5;
            C_BEQ:   return 3;
            C_ILL:   return 3;
            default: return 4;
        endcase
    endfunction

    // Expected outputs in cycle c (1 = fetch) of an instruction.
    function automatic logic [16:0] exp_vec(input int cls, input int c,
        input logic z, input logic [2:0] f3, input logic f7);
        logic e_pcw, e_adr, e_mw, e_irw, e_rw;
        logic [1:0] e_res, e_a, e_b, e_imm;
        logic [2:0] e_alu;
        case (cls)
            C_SW:    e_imm = 2'b01;
            C_BEQ:   e_imm = 2'b10;
            C_JAL:   e_imm = 2'b11;
            default: e_imm = 2'b00;
        endcase
        if (cls == C_ILL && c >= 3) return 17'd1;
        e_irw = (c == 1);
        e_pcw = (c == 1) || (c == 3 && (cls == C_JAL || (cls == C_BEQ && z)));
        e_mw  = (cls == C_SW && c == 4);
        e_rw  = (c == ncyc(cls)) &&
                (cls == C_LW || cls == C_R || cls == C_I || cls == C_JAL);
        e_adr = (cls == C_LW && c == 4) || e_mw;
        e_res = (c == 1) ? 2'b10 : (cls == C_LW && c == 5) ? 2'b01 : 2'b00;
        e_a = 2'b00; e_b = 2'b00; e_alu = 3'b000;
        if (c == 1) begin e_a = 2'b00; e_b = 2'b10; end
        else if (c == 2) begin e_a = 2'b01; e_b = 2'b01; end
        else if (c == 3) begin
            case (cls)
                C_LW, C_SW, C_I: begin e_a = 2'b10; e_b = 2'b01; end
                C_R, C_BEQ:      begin e_a = 2'b10; e_b = 2'b00; end
                C_JAL:           begin e_a = 2'b01; e_b = 2'b10; end
                default: ;
            endcase
            if (cls == C_BEQ) e_alu = 3'b001;
            if (cls == C_R || cls == C_I) begin
                case (f3)
                    3'b000:  e_alu = (cls == C_R && f7) ? 3'b001 : 3'b000;
                    3'b010:  e_alu = 3'b101;
                    3'b110:  e_alu = 3'b011;
                    3'b111:  e_alu = 3'b010;
                    default: e_alu = 3'b000;
                endcase
            end
        end
        return {e_pcw, e_adr, e_mw, e_irw, e_res, e_a, e_b, e_imm, e_rw, e_alu, 1'b0};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // zmode: 0/1 fixed zero flag, 2 random each cycle
    task automatic run_instr(input string name, input int cls,
        input logic [2:0] f3, input logic f7, input int zmode, input int first);
        logic [16:0] e;
        for (int c = first; c <= ncyc(cls); c++) begin
            op = op_of(cls); funct3 = f3; funct7b5 = f7;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            e = exp_vec(cls, c, zero, f3, f7);
            @(negedge clk);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, act, e);
            end
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL %s(halt0) cyc=%0d got=%h exp=%h", name, c, act0, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pcw, mw, irw, rw, ill, pcw0, mw0, irw0, rw0, ill0} !== 10'b0) begin
            errors++;
            $display("FAIL reset_enables got=%b exp=0",
                {pcw, mw, irw, rw, ill, pcw0, mw0, irw0, rw0, ill0});
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_lw();
        run_instr("lw", C_LW, 3'b010, 1'b0, 0, 1);
    endtask

    task automatic test_sw();
        run_instr("sw", C_SW, 3'b010, 1'b0, 0, 1);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", C_BEQ, 3'b000, 1'b0, 1, 1);
        run_instr("beq_not", C_BEQ, 3'b000, 1'b0, 0, 1);
    endtask

    task automatic test_alu();
        run_instr("r_sub", C_R, 3'b000, 1'b1, 0, 1);
        run_instr("r_and", C_R, 3'b111, 1'b0, 0, 1);
        run_instr("r_slt", C_R, 3'b010, 1'b0, 0, 1);
        run_instr("i_addi", C_I, 3'b000, 1'b1, 0, 1);
        run_instr("jal", C_JAL, 3'b000, 1'b0, 0, 1);
    endtask

    task automatic test_illegal();
        logic [16:0] e, e0;
        op = 7'b1111111;
        for (int c = 1; c <= 7; c++) begin
            e  = (c <= 2) ? exp_vec(C_ILL, c, 1'b0, 3'b0, 1'b0) : 17'd1;
            e0 = exp_vec(C_ILL, ((c - 1) % 3) + 1, 1'b0, 3'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL illegal_halt1 cyc=%0d got=%h exp=%h", c, act, e);
            end
            checks++;
            if (act0 !== e0) begin
                errors++;
                $display("FAIL illegal_halt0 cyc=%0d got=%h exp=%h", c, act0, e0);
            end
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        run_instr("sw_pre", C_SW, 3'b010, 1'b0, 0, 1);
        op = op_of(C_SW);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pcw, mw, irw, rw, ill} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=00000", {pcw, mw, irw, rw, ill});
        end
        @(posedge clk); #1 reset = 1'b0;
        run_instr("after_reset", C_LW, 3'b010, 1'b0, 0, 1);
    endtask

`ifdef MC_CTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        op = op_of(C_LW);
        mem_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({irw, pcw} !== 2'b00) begin
                errors++;
                $display("FAIL wait_fetch cyc=%0d got=%b exp=00", c, {irw, pcw});
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        run_instr("wait_release", C_LW, 3'b010, 1'b0, 0, 1);
        op = op_of(C_SW);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if ({mw, adr} !== 2'b11) begin
                errors++;
                $display("FAIL wait_memwrite cyc=%0d got=%b exp=11", c, {mw, adr});
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        run_instr("sw_release", C_SW, 3'b010, 1'b0, 0, 4);
    endtask
`endif

    task automatic test_random();
        logic [2:0] f3s [4];
        f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;
        for (int i = 0; i < 150; i++) begin
            run_instr("random", int'($urandom_range(0, 5)),
                f3s[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 2, 1);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_alu();
        test_illegal();
        test_reset_mid();
`ifdef MC_CTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
